stream_reader: RTL and testbench

Single-channel read-stream engine for one accelerator input node. It sits directly downstream of the control/status register block and takes one node's base address, transfer count and stride plus the start and abort pulses. It issues in-order word reads on a request/grant/rvalid memory port and buffers the responses in a FIFO. The buffered words are presented to the fabric input node on a valid/ready stream, and completion is reported back to the status register.

---
 rtl/stream_reader.sv | 200 ++++++++++++++++++++
 tb/tb_stream_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_reader.sv
// stream_reader: in-order word-read engine feeding a response FIFO and a valid/ready output stream.
// Define STREAM_READER_STALL_CNT_EN to build the stall_cycles_o backpressure counter.
module stream_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] size_i,
  input  logic [15:0] stride_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic [31:0] stall_cycles_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_addr;
  logic [15:0]   r_size;
  logic [15:0]   r_stride;
  logic [15:0]   r_req_cnt;
  logic [15:0]   r_out_cnt;
  logic [CW-1:0] r_pending;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_mem [FIFO_DEPTH];

  logic          w_start;
  logic          w_req;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_credit_ok;
  logic [CW-1:0] w_pending_nxt;

  // A start is only honoured from IDLE, and a simultaneous clear drops it.
  assign w_start       = start_i && (r_state == S_IDLE) && !clear_i;
  // Words in the FIFO plus words still in flight may never exceed the FIFO size.
  assign w_credit_ok   = ({1'b0, r_count} + {1'b0, r_pending}) < LP_DEPTH;
  assign w_req         = (r_state == S_RUN) && (r_req_cnt < r_size) && w_credit_ok;
  assign w_grant       = w_req && mem_gnt_i;
  assign w_rsp         = mem_rvalid_i && (r_pending != '0);
  // A grant in the clear cycle still produces a response, so it is counted for FLUSH.
  assign w_pending_nxt = r_pending + CW'(w_grant) - CW'(w_rsp);
  assign w_push        = mem_rvalid_i && !clear_i && ((r_state == S_RUN) || (r_state == S_WAIT));
  assign w_pop         = (r_count != '0) && data_ready_i;

  assign mem_req_o     = w_req;
  assign mem_addr_o    = r_addr;
  assign data_valid_o  = (r_count != '0);
  assign data_o        = (r_count != '0) ? r_mem[r_rd_ptr] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: outputs and next state get defaults first so no path through the block infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    busy_o      = (r_state != S_IDLE);
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (size_i == 16'h0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_grant && ((r_req_cnt + 16'd1) == r_size)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_out_cnt == r_size) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        if (w_pending_nxt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear_i) begin
      w_state_nxt = (w_pending_nxt != '0) ? S_FLUSH : S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr    <= 32'h0;
      r_size    <= 16'h0;
      r_stride  <= 16'h0;
      r_req_cnt <= 16'h0;
      r_out_cnt <= 16'h0;
      r_pending <= '0;
    end else if (w_start) begin
      r_addr    <= base_addr_i;
      r_size    <= size_i;
      r_stride  <= stride_i;
      r_req_cnt <= 16'h0;
      r_out_cnt <= 16'h0;
      r_pending <= '0;
    end else begin
      if (w_grant) begin
        r_addr    <= r_addr + {16'h0, r_stride};
        r_req_cnt <= r_req_cnt + 16'd1;
      end
      if (w_pop) begin
        r_out_cnt <= r_out_cnt + 16'd1;
      end
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear_i) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; data_o is gated by the occupancy count instead.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= mem_rdata_i;
    end
  end

`ifdef STREAM_READER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 32'h0;
    end else if (w_start) begin
      r_stall_cnt <= 32'h0;
    end else if (data_valid_o && !data_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
`else
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_stream_reader.sv
// tb_stream_reader: scoreboard bench for stream_reader with a behavioural in-order memory responder.
// Expected addresses/words are queued at launch and retired at each grant and stream handshake.
module tb_stream_reader;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        clear_i;
  logic [31:0] base_addr_i;
  logic [15:0] size_i;
  logic [15:0] stride_i;
  logic        busy_o;
  logic        done_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [31:0] stall_cycles_o;

  stream_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .base_addr_i(base_addr_i), .size_i(size_i), .stride_i(stride_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] resp_q[$];
  int          resp_due[$];

  // Responder / sink policy
  bit gnt_rand   = 1'b0;
  bit ready_rand = 1'b0;
  int gnt_limit  = 1 << 30;
  int lat        = 1;
  int stall_from = -1;
  int stall_to   = -1;

  // Per-test observations
  int grants, handshakes, done_cnt, done_cyc, first_hs, last_hs, max_outst, req_seen, start_cyc;
  bit          prev_wait;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic clear_obs();
    grants = 0; handshakes = 0; done_cnt = 0; done_cyc = -1;
    first_hs = -1; last_hs = -1; max_outst = 0; req_seen = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, then observe and score.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk_i);
    cyc++;
    start_i = 1'b0;
    clear_i = 1'b0;
    mem_gnt_i = (grants < gnt_limit) && (!gnt_rand || ($urandom_range(0, 1) == 1));
    if (resp_q.size() > 0 && resp_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = resp_q.pop_front();
      void'(resp_due.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'hDEAD_BEEF;
    end
    data_ready_i = !(cyc >= stall_from && cyc < stall_to) && (!ready_rand || ($urandom_range(0, 3) != 0));
    #1;
    if (prev_wait) begin
      vectors++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
        miscompares++;
        $display("FAIL req_hold cyc=%0d: req=%b addr=%h, required req=1 addr=%h", cyc, mem_req_o, mem_addr_o, prev_addr);
      end
    end
    prev_wait = mem_req_o && !mem_gnt_i;
    prev_addr = mem_addr_o;
    if (mem_req_o) req_seen++;
    if (mem_req_o && mem_gnt_i) begin
      grants++;
      vectors++;
      if (exp_addr.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_grant cyc=%0d: addr=%h, required no request", cyc, mem_addr_o);
      end else begin
        e = exp_addr.pop_front();
        if (mem_addr_o !== e) begin
          miscompares++;
          $display("FAIL mem_addr cyc=%0d: got %h, required %h", cyc, mem_addr_o, e);
        end
      end
      resp_q.push_back(mem_word(mem_addr_o));
      resp_due.push_back(cyc + lat);
    end
    if (data_valid_o && data_ready_i) begin
      handshakes++;
      vectors++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (exp_data.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_data cyc=%0d: got %h, required no word", cyc, data_o);
      end else begin
        e = exp_data.pop_front();
        if (data_o !== e) begin
          miscompares++;
          $display("FAIL stream_data cyc=%0d: got %h, required %h", cyc, data_o, e);
        end
      end
    end
    if (grants - handshakes > max_outst) max_outst = grants - handshakes;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic expect_linear(input logic [31:0] base, input logic [15:0] stride, input int n);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
      a = a + {16'h0, stride};
    end
  endtask

  // Issue start this cycle; expected words follow the queued expected addresses.
  task automatic launch(input logic [31:0] base, input logic [15:0] stride, input logic [15:0] size);
    for (int i = 0; i < exp_addr.size(); i++) exp_data.push_back(mem_word(exp_addr[i]));
    clear_obs();
    base_addr_i = base;
    stride_i    = stride;
    size_i      = size;
    start_i     = 1'b1;
    start_cyc   = cyc;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done_o within %0d cycles", name, bound);
    end
    repeat (3) tick();
  endtask

  task automatic check_end(input string name, input int words);
    vectors++;
    if (handshakes != words || exp_data.size() != 0 || exp_addr.size() != 0) begin
      miscompares++;
      $display("FAIL %s_words: got %0d words (%0d data/%0d addr left), required %0d (0/0 left)",
               name, handshakes, exp_data.size(), exp_addr.size(), words);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt);
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_after: got %b, required 0", name, busy_o);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({mem_req_o, data_valid_o, done_o, busy_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL %s_flags: req/valid/done/busy=%b, required 0000", name, {mem_req_o, data_valid_o, done_o, busy_o});
    end
    vectors++;
    if (mem_addr_o !== 32'h0 || data_o !== 32'h0 || stall_cycles_o !== 32'h0) begin
      miscompares++;
      $display("FAIL %s_values: addr=%h data=%h stall=%h, required all 0", name, mem_addr_o, data_o, stall_cycles_o);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic(input string name);
    expect_linear(32'h8000_0000, 16'd4, 20);
    launch(32'h8000_0000, 16'd4, 16'd20);
    wait_done(200, name);
    check_end(name, 20);
    vectors++;
    if (done_cyc != last_hs + 2) begin
      miscompares++;
      $display("FAIL %s_done_timing: done at %0d, required %0d", name, done_cyc, last_hs + 2);
    end
    vectors++;
    if (last_hs - first_hs != 19 || first_hs != start_cyc + 3) begin
      miscompares++;
      $display("FAIL %s_throughput: first/last hs at +%0d/+%0d, required +3/+22", name, first_hs - start_cyc, last_hs - start_cyc);
    end
  endtask

  task automatic test_zero_size();
    launch(32'h1234_5678, 16'd4, 16'd0);
    wait_done(10, "zero");
    vectors++;
    if (done_cyc != start_cyc + 1) begin
      miscompares++;
      $display("FAIL zero_done_timing: done at +%0d, required +1", done_cyc - start_cyc);
    end
    vectors++;
    if (req_seen != 0) begin
      miscompares++;
      $display("FAIL zero_no_req: %0d request cycles, required 0", req_seen);
    end
    check_end("zero", 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_stall;
`ifdef STREAM_READER_STALL_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    expect_linear(32'h0000_1000, 16'd16, 8);
    launch(32'h0000_1000, 16'd16, 16'd8);
    stall_from = start_cyc + 3;
    stall_to   = start_cyc + 13;
    wait_done(200, "bp");
    stall_from = -1;
    stall_to   = -1;
    check_end("bp", 8);
    vectors++;
    if (max_outst > DEPTH) begin
      miscompares++;
      $display("FAIL bp_credit: %0d words outstanding or buffered, required at most %0d", max_outst, DEPTH);
    end
    vectors++;
    if (stall_cycles_o !== exp_stall) begin
      miscompares++;
      $display("FAIL bp_stall_cnt: got %0d, required %0d", stall_cycles_o, exp_stall);
    end
  endtask

  task automatic test_wrap();
    exp_addr.push_back(32'hFFFF_FFF8);
    exp_addr.push_back(32'h0000_0000);
    exp_addr.push_back(32'h0000_0008);
    launch(32'hFFFF_FFF8, 16'd8, 16'd3);
    wait_done(50, "wrap");
    check_end("wrap", 3);
  endtask

  task automatic test_back_to_back();
    gnt_rand   = 1'b1;
    ready_rand = 1'b1;
    lat        = 3;
    expect_linear(32'h2000_0000, 16'hFFFC, 12);
    launch(32'h2000_0000, 16'hFFFC, 16'd12);
    repeat (6) tick();
    base_addr_i = 32'h7777_0000;
    size_i      = 16'd2;
    start_i     = 1'b1;
    wait_done(400, "b2b_a");
    check_end("b2b_a", 12);
    expect_linear(32'h3000_0040, 16'd0, 5);
    launch(32'h3000_0040, 16'd0, 16'd5);
    wait_done(400, "b2b_b");
    check_end("b2b_b", 5);
    gnt_rand   = 1'b0;
    ready_rand = 1'b0;
    lat        = 1;
  endtask

  task automatic test_abort();
    int n;
    lat       = 5;
    gnt_limit = 2;
    expect_linear(32'h4000_0000, 16'd4, 8);
    launch(32'h4000_0000, 16'd4, 16'd8);
    repeat (3) tick();
    clear_i   = 1'b1;
    prev_wait = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    tick();
    req_seen = 0; handshakes = 0; done_cnt = 0;
    vectors++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b1 || resp_q.size() != 2) begin
      miscompares++;
      $display("FAIL abort_flush_entry: req=%b busy=%b late=%0d, required req=0 busy=1 late=2", mem_req_o, busy_o, resp_q.size());
    end
    base_addr_i = 32'h5000_0000;
    size_i      = 16'd4;
    start_i     = 1'b1;
    n = 0;
    while (resp_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy_last_rvalid: got %b, required 1", busy_o);
    end
    tick();
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle_after: busy=%b, required 0", busy_o);
    end
    gnt_limit = 1 << 30;
    repeat (4) tick();
    vectors++;
    if (req_seen != 0 || handshakes != 0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: req=%0d words=%0d done=%0d, required 0/0/0", req_seen, handshakes, done_cnt);
    end
    lat = 1;
  endtask

  task automatic test_reset_mid_run();
    expect_linear(32'h8000_0000, 16'd4, 20);
    launch(32'h8000_0000, 16'd4, 16'd20);
    repeat (6) tick();
    #2 rst_i = 1'b1;
    prev_wait = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    resp_q.delete();
    resp_due.delete();
    exp_addr.delete();
    exp_data.delete();
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    test_basic("after_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    clear_i      = 1'b0;
    base_addr_i  = 32'h0;
    size_i       = 16'h0;
    stride_i     = 16'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    data_ready_i = 1'b1;
    prev_wait    = 1'b0;
    prev_addr    = 32'h0;
    clear_obs();
    #12;
    test_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    test_basic("basic");
    test_zero_size();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
